mul_div_unit: RTL and testbench

//  Iterative multiply/divide unit in the execute stage, beside the ALU; same operand buses.

---
 rtl/mul_div_pkg.sv | 33 +++
 rtl/mul_div_unit_if.sv | 31 +++
 rtl/md_sign_fix.sv | 36 +++
 rtl/mul_div_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state encoding, status-byte bit positions and the iteration-counter
// width helper.
package mul_div_pkg;

  localparam int unsigned MD_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } md_state_e;

  // Status byte layout, shared with the ALU flag meanings
  localparam int unsigned STAT_ZERO = 7;
  localparam int unsigned STAT_DIVZ = 6;
  localparam int unsigned STAT_OVF  = 5;
  localparam int unsigned STAT_NEG  = 4;

  // Counter holds 0..w-1 iteration index
  function automatic int unsigned md_cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Operand/result bus of the multiply/divide unit.
//   master: issues MD_start/MD_op/operands and MTHI/MTLO writes
//   slave : the unit; returns MD_busy, MD_done, MD_hi, MD_lo, MD_status
interface mul_div_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  MD_start;
  logic [1:0]            MD_op;
  logic [DATA_WIDTH-1:0] MD_operand_1;
  logic [DATA_WIDTH-1:0] MD_operand_2;
  logic                  MD_write_hi;
  logic                  MD_write_lo;
  logic [DATA_WIDTH-1:0] MD_write_data;
  logic                  MD_busy;
  logic                  MD_done;
  logic [DATA_WIDTH-1:0] MD_hi;
  logic [DATA_WIDTH-1:0] MD_lo;
  logic [7:0]            MD_status;

  modport master (
    output MD_start, MD_op, MD_operand_1, MD_operand_2,
           MD_write_hi, MD_write_lo, MD_write_data,
    input  MD_busy, MD_done, MD_hi, MD_lo, MD_status
  );

  modport slave (
    input  MD_start, MD_op, MD_operand_1, MD_operand_2,
           MD_write_hi, MD_write_lo, MD_write_data,
    output MD_busy, MD_done, MD_hi, MD_lo, MD_status
  );
endinterface

// File: rtl/md_sign_fix.sv
// Combinational sign handling for the multiply/divide unit.
//   Load side : op_a/op_b -> magnitudes mag_a/mag_b and sign bits neg_a/neg_b
//               (signs only taken when signed_op is set).
//   Fix side  : product and quotient negated when operand signs differ;
//               remainder takes the dividend sign.
module md_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic           signed_op,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic [W-1:0]   mag_a,
  output logic [W-1:0]   mag_b,
  output logic           neg_a,
  output logic           neg_b,
  input  logic           res_neg_a,
  input  logic           res_neg_b,
  input  logic [2*W-1:0] prod_in,
  input  logic [W-1:0]   quo_in,
  input  logic [W-1:0]   rem_in,
  output logic [2*W-1:0] prod_out,
  output logic [W-1:0]   quo_out,
  output logic [W-1:0]   rem_out
);

  always_comb begin
    neg_a    = signed_op & op_a[W-1];
    neg_b    = signed_op & op_b[W-1];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    prod_out = (res_neg_a ^ res_neg_b) ? -prod_in : prod_in;
    quo_out  = (res_neg_a ^ res_neg_b) ? -quo_in : quo_in;
    rem_out  = res_neg_a ? -rem_in : rem_in;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) writing HI/LO, with
// MTHI/MTLO writes and a start/busy/done handshake.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   md (slave) : start/op/operands, MTHI/MTLO strobes+data in;
//                busy, done pulse, HI, LO, status byte out
// Optional feature: define MD_EARLY_TERM_EN to let a multiply leave CALC as
// soon as the remaining multiplier bits are all zero.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MD_DATA_WIDTH
) (
  input logic          clk,
  input logic          reset,
  mul_div_unit_if.slave md
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = md_cnt_w(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic             dz_q, dz_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;   // product accumulator / remainder in [W-1:0]
  logic [2*W-1:0]   sh_q, sh_d;     // shifted multiplicand / divisor in [W-1:0]
  logic [W-1:0]     mq_q, mq_d;     // multiplier / dividend shifting into quotient
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [7:0]       status_q, status_d;

  logic             accept, dz_in, is_div_q, signed_q, last;
  logic [W-1:0]     mag_a, mag_b;
  logic             neg_a, neg_b;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quo_fix, rem_fix;
  logic [W:0]       trial;
  logic [W-1:0]     mq_shr, res_hi, res_lo;
  logic             res_zero, res_neg;

  assign accept   = md.MD_start && (state_q == S_IDLE || state_q == S_DONE);
  assign dz_in    = md.MD_op[1] && (md.MD_operand_2 == '0);
  assign is_div_q = (op_q == OP_DIVU) || (op_q == OP_DIV);
  assign signed_q = (op_q == OP_MULT) || (op_q == OP_DIV);

  md_sign_fix #(.W(W)) u_sign_fix (
    .signed_op (md.MD_op[0]),
    .op_a      (md.MD_operand_1),
    .op_b      (md.MD_operand_2),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .neg_a     (neg_a),
    .neg_b     (neg_b),
    .res_neg_a (neg_a_q),
    .res_neg_b (neg_b_q),
    .prod_in   (acc_q),
    .quo_in    (mq_q),
    .rem_in    (acc_q[W-1:0]),
    .prod_out  (prod_fix),
    .quo_out   (quo_fix),
    .rem_out   (rem_fix)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = dz_in ? S_FIX : S_CALC;
        else        state_d = S_IDLE;
      end
      S_CALC:  if (last) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    md.MD_busy   = (state_q == S_CALC) || (state_q == S_FIX);
    md.MD_done   = (state_q == S_DONE);
    md.MD_hi     = hi_q;
    md.MD_lo     = lo_q;
    md.MD_status = status_q;
  end

  // Datapath
  always_comb begin
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    mq_d     = mq_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    status_d = status_q;
    last     = 1'b0;
    res_hi   = '0;
    res_lo   = '0;
    res_zero = 1'b0;
    res_neg  = 1'b0;
    // Restoring-divide trial subtract; MSB set means the divisor did not fit
    trial  = {acc_q[W-1:0], mq_q[W-1]} - {1'b0, sh_q[W-1:0]};
    mq_shr = mq_q >> 1;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          op_d    = md_op_e'(md.MD_op);
          neg_a_d = neg_a;
          neg_b_d = neg_b;
          dz_d    = dz_in;
          ovf_d   = (md_op_e'(md.MD_op) == OP_DIV) &&
                    (md.MD_operand_1 == {1'b1, {(W-1){1'b0}}}) &&
                    (md.MD_operand_2 == '1);
          cnt_d   = '0;
          // Divide-by-zero parks |dividend| in the remainder slot so the
          // normal remainder sign rule restores the raw dividend for HI.
          acc_d   = dz_in ? {{W{1'b0}}, mag_a} : '0;
          mq_d    = md.MD_op[1] ? mag_a : mag_b;
          sh_d    = {{W{1'b0}}, (md.MD_op[1] ? mag_b : mag_a)};
        end else begin
          if (md.MD_write_hi) hi_d = md.MD_write_data;
          if (md.MD_write_lo) lo_d = md.MD_write_data;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          if (!trial[W]) begin
            acc_d = {{W{1'b0}}, trial[W-1:0]};
            mq_d  = {mq_q[W-2:0], 1'b1};
          end else begin
            acc_d = {{W{1'b0}}, acc_q[W-2:0], mq_q[W-1]};
            mq_d  = {mq_q[W-2:0], 1'b0};
          end
          last = (cnt_q == CNT_LAST);
        end else begin
          // Multiplicand shifts left so the partial product is exact at
          // every step, which is what makes early exit possible.
          if (mq_q[0]) acc_d = acc_q + sh_q;
          sh_d = sh_q << 1;
          mq_d = mq_shr;
`ifdef MD_EARLY_TERM_EN
          last = (cnt_q == CNT_LAST) || (mq_shr == '0);
`else
          last = (cnt_q == CNT_LAST);
`endif
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          res_lo   = dz_q ? '1 : quo_fix;
          res_hi   = rem_fix;
          res_zero = (res_lo == '0);
          res_neg  = res_lo[W-1];
        end else begin
          res_hi   = prod_fix[2*W-1:W];
          res_lo   = prod_fix[W-1:0];
          res_zero = ({res_hi, res_lo} == '0);
          res_neg  = res_hi[W-1];
        end
        hi_d     = res_hi;
        lo_d     = res_lo;
        status_d = '0;
        status_d[STAT_ZERO] = res_zero;
        status_d[STAT_DIVZ] = dz_q;
        status_d[STAT_OVF]  = ovf_q;
        // Negative only has meaning for a signed result
        status_d[STAT_NEG]  = signed_q & res_neg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_d_reg_clear();
    end else begin
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      mq_q     <= mq_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      status_q <= status_d;
    end
  end

  task automatic op_d_reg_clear();
    op_q     <= OP_MULTU;
    neg_a_q  <= 1'b0;
    neg_b_q  <= 1'b0;
    dz_q     <= 1'b0;
    ovf_q    <= 1'b0;
    cnt_q    <= '0;
    acc_q    <= '0;
    sh_q     <= '0;
    mq_q     <= '0;
    hi_q     <= '0;
    lo_q     <= '0;
    status_q <= '0;
  endtask

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  import mul_div_pkg::*;

`ifdef MD_EARLY_TERM_EN
  localparam int LAT_MULT_3x5 = 5;
`else
  localparam int LAT_MULT_3x5 = 34;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  st;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mul_div_unit_if #(.DATA_WIDTH(32)) md_if ();

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && md_if.MD_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"}, md_if.MD_hi, e.hi);
        check({e.name, "_lo"}, md_if.MD_lo, e.lo);
        check({e.name, "_status"}, {24'h0, md_if.MD_status}, {24'h0, e.st});
        check({e.name, "_done_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input string name, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic [7:0] est, input int lat);
    exp_t e;
    md_if.MD_op        = op;
    md_if.MD_operand_1 = a;
    md_if.MD_operand_2 = b;
    md_if.MD_start     = 1'b1;
    if (push) begin
      e.name = name; e.hi = ehi; e.lo = elo; e.st = est; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    md_if.MD_start     = 1'b0;
    md_if.MD_write_hi  = 1'b0;
    md_if.MD_write_lo  = 1'b0;
    // Scramble inputs after acceptance; the running op must not see them
    md_if.MD_op        = ~op;
    md_if.MD_operand_1 = 32'h5A5A_A5A5;
    md_if.MD_operand_2 = 32'h0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (md_if.MD_done === 1'b1) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s_timeout: got no done in 200 cycles expected done", name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    md_if.MD_start = 1'b0; md_if.MD_op = 2'b00;
    md_if.MD_operand_1 = '0; md_if.MD_operand_2 = '0;
    md_if.MD_write_hi = 1'b0; md_if.MD_write_lo = 1'b0; md_if.MD_write_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_busy", {31'h0, md_if.MD_busy}, 32'h0);
    check("rst_done", {31'h0, md_if.MD_done}, 32'h0);
    check("rst_hi", md_if.MD_hi, 32'h0);
    check("rst_lo", md_if.MD_lo, 32'h0);
    check("rst_status", {24'h0, md_if.MD_status}, 32'h0);

    // MTHI in IDLE
    md_if.MD_write_hi = 1'b1; md_if.MD_write_data = 32'h1234;
    @(posedge clk); #1;
    md_if.MD_write_hi = 1'b0;
    check("mthi_hi", md_if.MD_hi, 32'h1234);
    check("mthi_lo", md_if.MD_lo, 32'h0);

    // MULTU max*max; MTLO while busy and a start while busy are both ignored
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 8'h00, 34);
    idle(2);
    md_if.MD_write_lo = 1'b1; md_if.MD_write_data = 32'h5555;
    @(posedge clk); #1;
    md_if.MD_write_lo = 1'b0;
    check("mtlo_busy_lo", md_if.MD_lo, 32'h0);
    check("busy_mid", {31'h0, md_if.MD_busy}, 32'h1);
    idle(6);
    issue(OP_DIVU, 32'h7, 32'h0, 0, "", '0, '0, '0, 0);
    check("busy_after_ignored_start", {31'h0, md_if.MD_busy}, 32'h1);
    wait_done("multu_max");

    idle(2);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'h5, 1, "mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 8'h10, LAT_MULT_3x5);
    wait_done("mult_m3x5");

    idle(1);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1, "div_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 8'h10, 34);
    wait_done("div_m7d2");

    idle(1);
    issue(OP_DIVU, 32'h7, 32'h0, 1, "divu_7d0", 32'h7, 32'hFFFF_FFFF, 8'h40, 2);
    wait_done("divu_7d0");
    // Back-to-back starts issued in the DONE cycle
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_ovf", 32'h0, 32'h8000_0000, 8'h30, 34);
    wait_done("div_ovf");
    issue(OP_DIVU, 32'h0, 32'h5, 1, "divu_0d5", 32'h0, 32'h0, 8'h80, 34);
    wait_done("divu_0d5");

    // Start and MTLO in the same cycle: write dropped
    idle(2);
    md_if.MD_write_lo = 1'b1; md_if.MD_write_data = 32'hDEAD;
    issue(OP_MULTU, 32'h2, 32'h3, 1, "multu_2x3", 32'h0, 32'h6, 8'h00, 34);
    check("start_mtlo_lo", md_if.MD_lo, 32'h0);
    wait_done("multu_2x3");

    idle(1);
    issue(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1, "div_100dm7", 32'h2, 32'hFFFF_FFF2, 8'h10, 34);
    wait_done("div_100dm7");

    idle(1);
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1, "mult_minsq", 32'h4000_0000, 32'h0, 8'h00, 34);
    wait_done("mult_minsq");

    // Both write strobes together
    idle(2);
    md_if.MD_write_hi = 1'b1; md_if.MD_write_lo = 1'b1; md_if.MD_write_data = 32'hABCD;
    @(posedge clk); #1;
    md_if.MD_write_hi = 1'b0; md_if.MD_write_lo = 1'b0;
    check("both_wr_hi", md_if.MD_hi, 32'hABCD);
    check("both_wr_lo", md_if.MD_lo, 32'hABCD);
    check("status_held", {24'h0, md_if.MD_status}, 32'h0);

    // Reset during cycle 10 of a MULTU
    issue(OP_MULTU, 32'h3, 32'h4, 0, "", '0, '0, '0, 0);
    idle(9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", {31'h0, md_if.MD_busy}, 32'h0);
    check("midrst_hi", md_if.MD_hi, 32'h0);
    check("midrst_lo", md_if.MD_lo, 32'h0);
    check("midrst_status", {24'h0, md_if.MD_status}, 32'h0);

    idle(40);
    check("sb_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected finish");
    $fatal(1);
  end

endmodule
